// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and the
// register-ID type used by the decode and register-file logic.
package y86_pkg;

  typedef logic [3:0] reg_id_t;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RSP   = 4'h4;

endpackage

// File: rtl/y86_src_decode.sv
// Decode-stage source selection: maps icode/rA/rB to the two read IDs.
// Pure combinational so the hazard unit can instantiate it as well.
module y86_src_decode
  import y86_pkg::*;
(
  input  logic [3:0] d_icode,
  input  reg_id_t    d_rA,
  input  reg_id_t    d_rB,
  output reg_id_t    srcA,
  output reg_id_t    srcB
);

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    case (d_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = d_rA;
      I_RET, I_POPQ:                      srcA = RSP;
      default:                            srcA = RNONE;
    endcase
    case (d_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = d_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = RSP;
      default:                            srcB = RNONE;
    endcase
  end

endmodule

// File: rtl/y86_pipe_regfile.sv
// Pipelined Y86-64 register file: two bypassed read ports, E and M
// write-back ports (M wins on a shared destination), and a raw debug port.
module y86_pipe_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int NUM_REGS    = 15,
  parameter int RESET_INDEX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        d_icode,
  input  reg_id_t           d_rA,
  input  reg_id_t           d_rB,
  output reg_id_t           srcA,
  output reg_id_t           srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic              w_en,
  input  reg_id_t           w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  reg_id_t           w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  input  reg_id_t           dbg_idx,
  output logic [DATA_W-1:0] dbg_val
);

  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  // Array is always 16 deep so any 4-bit ID indexes it; entries at or
  // above NUM_REGS are held at zero and never read.
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];

  function automatic logic id_valid(input reg_id_t id);
    return (id != RNONE) && ({1'b0, id} < NUM_REGS_W);
  endfunction

  function automatic logic [DATA_W-1:0] reset_val(input int idx);
    if (RESET_INDEX != 0) return DATA_W'(idx);
    return '0;
  endfunction

  y86_src_decode u_src_decode (
    .d_icode (d_icode),
    .d_rA    (d_rA),
    .d_rB    (d_rB),
    .srcA    (srcA),
    .srcB    (srcB)
  );

  // Reset overrides any write; M is applied after E so it wins a shared dst.
  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_d[i] = reset_val(i);
    end else if (w_en) begin
      if (id_valid(w_dstE)) regs_d[w_dstE] = w_valE;
      if (id_valid(w_dstM)) regs_d[w_dstM] = w_valM;
    end
    for (int i = 0; i < 16; i++) begin
      if (i >= NUM_REGS) regs_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  function automatic logic [DATA_W-1:0] read_port(input reg_id_t id);
    if (!id_valid(id))                   return '0;
    if (!reset && w_en && id == w_dstM)  return w_valM;
    if (!reset && w_en && id == w_dstE)  return w_valE;
    return regs_q[id];
  endfunction

  always_comb begin
    valA    = read_port(srcA);
    valB    = read_port(srcB);
    dbg_val = id_valid(dbg_idx) ? regs_q[dbg_idx] : '0;
  end

endmodule

// File: tb/tb_y86_pipe_regfile.sv
// Bench for y86_pipe_regfile: directed vectors push expected values into a
// queue; a negedge monitor pops them and compares against the DUT outputs.
module tb_y86_pipe_regfile;
  import y86_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  d_icode;
  reg_id_t     d_rA, d_rB;
  reg_id_t     srcA, srcB, srcA0, srcB0;
  logic [63:0] valA, valB, valA0, valB0;
  logic        w_en;
  reg_id_t     w_dstE, w_dstM;
  logic [63:0] w_valE, w_valM;
  reg_id_t     dbg_idx;
  logic [63:0] dbg_val, dbg_val0;

  // Output selectors: 0 valA, 1 valB, 2 srcA, 3 srcB, 4 dbg_val, 5 dbg_val of zero-reset copy
  logic [63:0] exp_q[$];
  int          sel_q[$];
  int          id_q[$];
  int          n_cmp;
  int          n_fail;
  int          n_id;

  y86_pipe_regfile #(.DATA_W(64), .NUM_REGS(15), .RESET_INDEX(1)) dut (
    .clk(clk), .reset(reset), .d_icode(d_icode), .d_rA(d_rA), .d_rB(d_rB),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB), .w_en(w_en),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .dbg_idx(dbg_idx), .dbg_val(dbg_val)
  );

  y86_pipe_regfile #(.DATA_W(64), .NUM_REGS(15), .RESET_INDEX(0)) dut0 (
    .clk(clk), .reset(reset), .d_icode(d_icode), .d_rA(d_rA), .d_rB(d_rB),
    .srcA(srcA0), .srcB(srcB0), .valA(valA0), .valB(valB0), .w_en(w_en),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .dbg_idx(dbg_idx), .dbg_val(dbg_val0)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [63:0] v);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    id_q.push_back(n_id);
    n_id++;
  endtask

  task automatic drive_d(input logic [3:0] ic, input reg_id_t ra, input reg_id_t rb);
    d_icode = ic;
    d_rA    = ra;
    d_rB    = rb;
  endtask

  task automatic drive_w(input logic en, input reg_id_t de, input logic [63:0] ve,
                         input reg_id_t dm, input logic [63:0] vm);
    w_en   = en;
    w_dstE = de;
    w_valE = ve;
    w_dstM = dm;
    w_valM = vm;
  endtask

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      0:       return valA;
      1:       return valB;
      2:       return {60'd0, srcA};
      3:       return {60'd0, srcB};
      4:       return dbg_val;
      5:       return dbg_val0;
      default: return 64'hX;
    endcase
  endfunction

  // Scoreboard monitor
  initial begin
    string names [6] = '{"valA", "valB", "srcA", "srcB", "dbg_val", "dbg_val_rst0"};
    n_cmp  = 0;
    n_fail = 0;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        automatic int          s  = sel_q.pop_front();
        automatic logic [63:0] e  = exp_q.pop_front();
        automatic int          id = id_q.pop_front();
        automatic logic [63:0] a  = pick(s);
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL chk%0d %s: got %h expected %h", id, names[s], a, e);
        end
      end
    end
  end

  // Directed stimulus
  logic [3:0] exp_sa [16] = '{4'hF, 4'hF, 4'h1, 4'hF, 4'h1, 4'hF, 4'h1, 4'hF,
                              4'hF, 4'h4, 4'h1, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0] exp_sb [16] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h2, 4'h2, 4'h2, 4'hF,
                              4'h4, 4'h4, 4'h4, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF};

  initial begin
    n_id  = 0;
    reset = 1'b1;
    drive_d(I_NOP, 4'h0, 4'h0);
    drive_w(1'b0, RNONE, 64'h0, RNONE, 64'h0);
    dbg_idx = 4'h0;
    step();
    // Reset high: array already reset, bypass must be suppressed
    drive_d(I_OPQ, 4'h3, 4'h5);
    drive_w(1'b1, 4'h3, 64'hDEAD, 4'h5, 64'hBEEF);
    expect_out(0, 64'd3);
    expect_out(1, 64'd5);
    step();

    // Post-reset NOP outputs and debug sweep
    reset = 1'b0;
    drive_d(I_NOP, 4'h0, 4'h0);
    drive_w(1'b0, RNONE, 64'h0, RNONE, 64'h0);
    expect_out(2, 64'hF);
    expect_out(3, 64'hF);
    expect_out(0, 64'h0);
    expect_out(1, 64'h0);
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      expect_out(4, (i < 15) ? 64'(i) : 64'h0);
      expect_out(5, 64'h0);
      step();
    end

    // E write with same-cycle bypass, then committed value
    drive_d(I_OPQ, 4'h3, 4'h0);
    drive_w(1'b1, 4'h3, 64'hDEAD, RNONE, 64'h0);
    expect_out(0, 64'hDEAD);
    expect_out(1, 64'h0);
    step();
    drive_w(1'b0, RNONE, 64'h0, RNONE, 64'h0);
    dbg_idx = 4'h3;
    expect_out(4, 64'hDEAD);
    expect_out(0, 64'hDEAD);
    step();

    // popq %rsp: M wins over E on both bypass and storage
    drive_d(I_POPQ, 4'h0, 4'h0);
    drive_w(1'b1, 4'h4, 64'h100, 4'h4, 64'h55);
    expect_out(2, 64'h4);
    expect_out(3, 64'h4);
    expect_out(0, 64'h55);
    expect_out(1, 64'h55);
    step();
    drive_w(1'b0, RNONE, 64'h0, RNONE, 64'h0);
    dbg_idx = 4'h4;
    expect_out(4, 64'h55);
    step();

    // w_en low: no bypass, no write
    drive_d(I_OPQ, 4'h2, RNONE);
    drive_w(1'b0, 4'h2, 64'h7, RNONE, 64'h0);
    expect_out(0, 64'h2);
    expect_out(1, 64'h0);
    step();
    drive_w(1'b0, RNONE, 64'h0, RNONE, 64'h0);
    dbg_idx = 4'h2;
    expect_out(4, 64'h2);
    step();

    // Distinct E and M destinations in one cycle; RNONE dst ignored
    drive_d(I_OPQ, 4'h7, 4'h8);
    drive_w(1'b1, 4'h7, 64'hAA, 4'h8, 64'hBB);
    expect_out(0, 64'hAA);
    expect_out(1, 64'hBB);
    step();
    drive_w(1'b1, RNONE, 64'h123, RNONE, 64'h456);
    drive_d(I_OPQ, 4'h6, RNONE);
    dbg_idx = 4'h7;
    expect_out(4, 64'hAA);
    expect_out(0, 64'h6);
    expect_out(1, 64'h0);
    step();
    drive_w(1'b0, RNONE, 64'h0, RNONE, 64'h0);
    dbg_idx = 4'h8;
    expect_out(4, 64'hBB);
    step();

    // Reset in the same cycle as a write: write dropped
    reset = 1'b1;
    drive_w(1'b1, 4'h5, 64'h99, RNONE, 64'h0);
    step();
    reset = 1'b0;
    drive_w(1'b0, RNONE, 64'h0, RNONE, 64'h0);
    dbg_idx = 4'h5;
    expect_out(4, 64'h5);
    expect_out(5, 64'h0);
    step();
    dbg_idx = 4'h3;
    expect_out(4, 64'h3);
    expect_out(5, 64'h0);
    step();
    dbg_idx = 4'h4;
    expect_out(4, 64'h4);
    step();

    // Decode sweep with rA=1, rB=2
    for (int ic = 0; ic < 16; ic++) begin
      drive_d(4'(ic), 4'h1, 4'h2);
      expect_out(2, {60'd0, exp_sa[ic]});
      expect_out(3, {60'd0, exp_sb[ic]});
      step();
    end

    step();
    step();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
